// File: rtl/tone_decoder_if.sv
// rtl/tone_decoder_if.sv - tone line in, note status out; dur exists only with TONE_DECODER_DURATION_EN
interface tone_decoder_if #(
    parameter int PW = 20
);
    logic          tone_in;
    logic [3:0]    note;
    logic          note_strobe;
    logic [PW-1:0] period;
    logic          locked;
`ifdef TONE_DECODER_DURATION_EN
    logic [26:0]   dur;

    modport master (output tone_in, input note, note_strobe, period, locked, dur);
    modport slave  (input tone_in, output note, note_strobe, period, locked, dur);
`else
    modport master (output tone_in, input note, note_strobe, period, locked);
    modport slave  (input tone_in, output note, note_strobe, period, locked);
`endif
endinterface

// File: rtl/tone_decoder.sv
// rtl/tone_decoder.sv - square-wave period measurement and 12-note classifier
// Optional note-duration output under TONE_DECODER_DURATION_EN.
module tone_decoder #(
    parameter int CLK_HZ     = 50000000,
    parameter int PW         = 20,
    parameter int TOL_SHIFT  = 6,
    parameter int STABLE_CNT = 2,
    parameter int TIMEOUT    = 400000
) (
    input  logic         clk,
    input  logic         rst,
    tone_decoder_if.slave bus
);
    typedef enum logic [1:0] {SILENT, ARMED, TRACK} state_t;

    localparam logic [2:0] STABLE = 3'(STABLE_CNT);

    function automatic logic [63:0] note_chz(input int i);
        case (i)
            0:       return 64'd44000;
            1:       return 64'd49388;
            2:       return 64'd26163;
            3:       return 64'd29366;
            4:       return 64'd32963;
            5:       return 64'd34923;
            6:       return 64'd39200;
            7:       return 64'd46616;
            8:       return 64'd52325;
            9:       return 64'd55437;
            10:      return 64'd58733;
            default: return 64'd41530;
        endcase
    endfunction

    logic          sync1, tone_s, tone_d, rise;
    logic [PW-1:0] cnt;
    logic          timeout;
    logic [11:0]   hit;
    logic [3:0]    idx;

    state_t        state, state_n;
    logic [3:0]    cand, cand_n, note, note_n;
    logic [2:0]    mcount, mcount_n;
    logic [PW-1:0] period, period_n;
    logic          strobe, strobe_n, locked;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1  <= 1'b0;
            tone_s <= 1'b0;
            tone_d <= 1'b0;
        end else begin
            sync1  <= bus.tone_in;
            tone_s <= sync1;
            tone_d <= tone_s;
        end
    end

    assign rise = tone_s & ~tone_d;

    // Saturating so a dead line can never wrap back into a valid note period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (rise)
            cnt <= PW'(1);
        else if (cnt != '1)
            cnt <= cnt + PW'(1);
    end

    assign timeout = (cnt == PW'(TIMEOUT));

    for (genvar g = 0; g < 12; g++) begin : g_tab
        localparam logic [63:0] NOM = (64'(CLK_HZ) * 64'd100) / note_chz(g);
        localparam logic [63:0] TOL = NOM >> TOL_SHIFT;
        assign hit[g] = (64'(cnt) >= NOM - TOL) && (64'(cnt) <= NOM + TOL);
    end

    // Scanning downward leaves the lowest matching index in idx.
    always_comb begin
        idx = 4'd15;
        for (int i = 11; i >= 0; i--)
            if (hit[i]) idx = 4'(i + 1);
    end

    always_comb begin
        state_n  = state;
        cand_n   = cand;
        mcount_n = mcount;
        note_n   = note;
        period_n = period;
        strobe_n = 1'b0;
        case (state)
            SILENT: begin
                if (rise) state_n = ARMED;
            end
            ARMED: begin
                if (rise) begin
                    period_n = cnt;
                    cand_n   = idx;
                    mcount_n = 3'd1;
                    state_n  = TRACK;
                end else if (timeout) begin
                    state_n = SILENT;
                end
            end
            TRACK: begin
                if (rise) begin
                    period_n = cnt;
                    if (idx == cand) begin
                        if (mcount < STABLE) mcount_n = mcount + 3'd1;
                    end else begin
                        cand_n   = idx;
                        mcount_n = 3'd1;
                    end
                    if (mcount_n == STABLE && cand_n != note) begin
                        note_n   = cand_n;
                        strobe_n = 1'b1;
                    end
                end else if (timeout) begin
                    state_n  = SILENT;
                    cand_n   = 4'd0;
                    mcount_n = 3'd0;
                    if (note != 4'd0) begin
                        note_n   = 4'd0;
                        strobe_n = 1'b1;
                    end
                end
            end
            default: state_n = SILENT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= SILENT;
            cand   <= 4'd0;
            mcount <= 3'd0;
            note   <= 4'd0;
            period <= '0;
            strobe <= 1'b0;
            locked <= 1'b0;
        end else begin
            state  <= state_n;
            cand   <= cand_n;
            mcount <= mcount_n;
            note   <= note_n;
            period <= period_n;
            strobe <= strobe_n;
            locked <= (note_n != 4'd0) && (note_n != 4'd15);
        end
    end

    assign bus.note        = note;
    assign bus.note_strobe = strobe;
    assign bus.period      = period;
    assign bus.locked      = locked;

`ifdef TONE_DECODER_DURATION_EN
    logic [26:0] dcnt, dur;

    // Restart beats count on the commit edge itself, so dur is commit-to-commit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dcnt <= 27'd0;
            dur  <= 27'd0;
        end else begin
            if (strobe_n) dur <= dcnt;
            if (state != SILENT && state_n == SILENT)
                dcnt <= 27'd0;
            else if (strobe_n)
                dcnt <= 27'd1;
            else if (state == TRACK && dcnt != '1)
                dcnt <= dcnt + 27'd1;
        end
    end

    assign bus.dur = dur;
`endif
endmodule

// File: tb/tb_tone_decoder.sv
// tb/tb_tone_decoder.sv - randomized and directed check of tone_decoder against a timestamp model
module tb_tone_decoder;
    localparam int CLK_HZ    = 200000;
    localparam int PW        = 20;
    localparam int TOL_SHIFT = 6;
    localparam int STABLE    = 2;
    localparam int TIMEOUT   = 1600;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tone_decoder_if #(.PW(PW)) bus ();

    tone_decoder #(
        .CLK_HZ(CLK_HZ), .PW(PW), .TOL_SHIFT(TOL_SHIFT),
        .STABLE_CNT(STABLE), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int vectors = 0;
    int miscompares = 0;
    int edge_n = 0;
    int strobes = 0;
    int last_strobe_edge = 0;

    int rq[$];
    int hist[$];
    bit seen = 0;
    int last_rise = 0;
    int dstart = 0;
    int m_note = 0, m_period = 0, m_strobe = 0, m_dur = 0;

    always @(posedge clk) edge_n <= edge_n + 1;

    function automatic longint chz(input int i);
        case (i)
            1: return 44000;  2: return 49388;  3: return 26163;  4: return 29366;
            5: return 32963;  6: return 34923;  7: return 39200;  8: return 46616;
            9: return 52325; 10: return 55437; 11: return 58733; default: return 41530;
        endcase
    endfunction

    function automatic int nominal(input int i);
        return int'((longint'(CLK_HZ) * 100) / chz(i));
    endfunction

    function automatic int classify(input int p);
        for (int i = 1; i <= 12; i++) begin
            int nom = nominal(i);
            int tol = nom >> TOL_SHIFT;
            if (p >= nom - tol && p <= nom + tol) return i;
        end
        return 15;
    endfunction

    function automatic bit settled(input int c);
        if (hist.size() < STABLE) return 0;
        for (int i = hist.size() - STABLE; i < hist.size(); i++)
            if (hist[i] != c) return 0;
        return 1;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s at edge %0d: got %0d, expected %0d", name, edge_n, act, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        m_strobe = 0;
        if (rst) begin
            rq.delete();
            hist.delete();
            seen = 0;
            m_note = 0;
            m_period = 0;
            m_dur = 0;
            dstart = 0;
        end else if (rq.size() > 0 && rq[0] == edge_n) begin
            void'(rq.pop_front());
            if (seen) begin
                int c;
                m_period = edge_n - last_rise;
                c = classify(m_period);
                if (hist.size() == 0) dstart = edge_n + 1;
                hist.push_back(c);
                if (settled(c) && c != m_note) begin
                    m_note = c;
                    m_strobe = 1;
                    m_dur = edge_n - dstart;
                    dstart = edge_n;
                end
            end
            seen = 1;
            last_rise = edge_n;
        end else if (seen && edge_n - last_rise == TIMEOUT) begin
            seen = 0;
            hist.delete();
            if (m_note != 0) begin
                m_note = 0;
                m_strobe = 1;
                m_dur = edge_n - dstart;
            end
        end
        chk("note", bus.note, m_note);
        chk("strobe", bus.note_strobe, m_strobe);
        chk("period", bus.period, m_period);
        chk("locked", bus.locked, (m_note != 0 && m_note != 15));
`ifdef TONE_DECODER_DURATION_EN
        chk("dur", bus.dur, m_dur);
`endif
        if (bus.note_strobe) begin
            strobes++;
            last_strobe_edge = edge_n;
        end
    end

    task automatic tone_rise();
        bus.tone_in = 1'b1;
        rq.push_back(edge_n + 3);
    endtask

    task automatic tone_cycle(input int p, input int hi);
        tone_rise();
        repeat (hi) @(negedge clk);
        bus.tone_in = 1'b0;
        repeat (p - hi) @(negedge clk);
    endtask

    task automatic reset_pulse(input bit toggle);
        rst = 1'b1;
        repeat (12) begin
            if (toggle) bus.tone_in = ~bus.tone_in;
            @(negedge clk);
        end
        bus.tone_in = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int s0, r_last, p, k, n, nom, tol;
        bus.tone_in = 1'b0;
        @(negedge clk);
        reset_pulse(1);
        repeat (5) @(negedge clk);

        s0 = strobes;
        repeat (3) tone_cycle(454, 227);
        chk("a4_note", bus.note, 1);
        chk("a4_period", bus.period, 454);
        chk("a4_locked", bus.locked, 1);
        chk("a4_strobes", strobes - s0, 1);
        repeat (3) tone_cycle(454, 200);
        chk("a4_no_more_strobes", strobes - s0, 1);

        s0 = strobes;
        repeat (2) tone_cycle(340, 170);
        chk("d5_first_keeps_a4", bus.note, 1);
        chk("d5_first_period", bus.period, 340);
        tone_cycle(340, 170);
        chk("d5_commit", bus.note, 11);
        chk("d5_strobes", strobes - s0, 1);

        repeat (4) tone_cycle(461, 230);
        chk("tol_edge_in", bus.note, 1);
        chk("tol_edge_period", bus.period, 461);
        repeat (3) tone_cycle(462, 231);
        chk("tol_edge_out", bus.note, 15);
        chk("tol_edge_unlocked", bus.locked, 0);

        repeat (4) tone_cycle(510, 255);
        chk("g4_note", bus.note, 7);
        s0 = strobes;
        r_last = edge_n + 3;
        tone_cycle(TIMEOUT + 20, 255);
        chk("silence_note", bus.note, 0);
        chk("silence_strobes", strobes - s0, 1);
        chk("silence_at_timeout", last_strobe_edge - r_last, TIMEOUT);

        s0 = strobes;
        tone_rise();
        repeat (5) @(negedge clk);
        bus.tone_in = 1'b0;
        repeat (50) @(negedge clk);
        chk("armed_note", bus.note, 0);
        chk("armed_no_strobe", strobes - s0, 0);
        repeat (TIMEOUT - 55) @(negedge clk);
        tone_rise();
        repeat (10) @(negedge clk);
        chk("rise_beats_timeout", bus.period, TIMEOUT);
        chk("rise_beats_timeout_note", bus.note, 0);
        bus.tone_in = 1'b0;
        repeat (400) @(negedge clk);

        for (int s = 0; s < 16; s++) begin
            if (s == 8) reset_pulse(0);
            if ($urandom_range(0, 3) == 0)
                repeat (TIMEOUT + $urandom_range(0, 100)) @(negedge clk);
            k = $urandom_range(0, 12);
            n = $urandom_range(2, 4);
            for (int j = 0; j < n; j++) begin
                if (k == 0) begin
                    p = $urandom_range(300, 900);
                end else begin
                    nom = nominal(k);
                    tol = nom >> TOL_SHIFT;
                    p = nom - tol + $urandom_range(0, 2 * tol);
                end
                tone_cycle(p, $urandom_range(3, p - 3));
            end
        end

`ifdef TONE_DECODER_DURATION_EN
        repeat (TIMEOUT + 10) @(negedge clk);
        repeat (51) tone_cycle(606, 303);
        repeat (3) tone_cycle(572, 286);
        chk("dur_f4_note", bus.note, 6);
        chk("dur_e4_to_f4", bus.dur, 49 * 606 + 2 * 572);
`endif

        repeat (TIMEOUT + 10) @(negedge clk);
        chk("final_silent", bus.note, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
